// File: rtl/seq_pkg.sv
// Shared types and helpers for the board sequencer.
// State encodings, board source codes and saturating score add.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GEN    = 3'd1,
        S_PLAY   = 3'd2,
        S_ELIM   = 3'd3,
        S_REFILL = 3'd4,
        S_OVER   = 3'd5
    } state_e;

    localparam logic BOARD_SRC_GEN     = 1'b0;
    localparam logic BOARD_SRC_REFRESH = 1'b1;

    function automatic logic [31:0] score_sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] max
    );
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max}) ? max : sum[31:0];
    endfunction

endpackage

// File: rtl/board_sequencer_if.sv
// Handshake bundle between the board sequencer and the game units.
// master = unit/stimulus side, slave = sequencer side.
interface board_sequencer_if #(
    parameter int SCORE_W = 10
) ();

    logic               start;
    logic               confirm;
    logic               gen_done;
    logic               elim_done;
    logic [6:0]         elim_count;
    logic               refill_done;
    logic               gen_req;
    logic               elim_req;
    logic               refill_req;
    logic               board_we;
    logic               board_sel;
    logic [SCORE_W-1:0] score;
    logic [7:0]         moves;
    logic [2:0]         state;
    logic               busy;
    logic               game_over;
    logic               timeout_err;

    modport master (
        output start, confirm, gen_done,
        output elim_done, elim_count, refill_done,
        input  gen_req, elim_req, refill_req,
        input  board_we, board_sel, score, moves,
        input  state, busy, game_over, timeout_err
    );

    modport slave (
        input  start, confirm, gen_done,
        input  elim_done, elim_count, refill_done,
        output gen_req, elim_req, refill_req,
        output board_we, board_sel, score, moves,
        output state, busy, game_over, timeout_err
    );

endinterface

// File: rtl/seq_phase_timer.sv
// Phase watchdog: counts cycles spent in a phase, flags the last one.
// clear wins over enable so each phase starts from zero.
module seq_phase_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/board_sequencer.sv
// Game flow controller: generate, play, eliminate, refill, with watchdog.
// Define SEQ_WIN_LIMIT_EN to end the game once score reaches WIN_SCORE.
import seq_pkg::*;

module board_sequencer #(
    parameter int TIMEOUT   = 1024,
    parameter int SCORE_W   = 10,
    parameter int WIN_SCORE = 500
) (
    input  logic              clk,
    input  logic              rst,
    board_sequencer_if.slave  bus
);

    localparam logic [31:0] SCORE_MAX = 32'({SCORE_W{1'b1}});

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [7:0]         moves_q, moves_d;
    logic               timeout_err_q, timeout_err_d;
    logic               gen_req_q, elim_req_q, refill_req_q;
    logic               board_we, board_sel;
    logic               busy, expired, win_reached;

    assign busy = (state_q == S_GEN) || (state_q == S_ELIM) ||
                  (state_q == S_REFILL);

`ifdef SEQ_WIN_LIMIT_EN
    assign win_reached   = 32'(score_q) >= 32'(WIN_SCORE);
    assign bus.game_over = (state_q == S_OVER);
`else
    assign win_reached   = 1'b0;
    assign bus.game_over = 1'b0;
`endif

    seq_phase_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_d != state_q),
        .enable  (busy),
        .expired (expired)
    );

    always_comb begin
        state_d       = state_q;
        score_d       = score_q;
        moves_d       = moves_q;
        timeout_err_d = timeout_err_q;
        board_we      = 1'b0;
        board_sel     = BOARD_SRC_GEN;
        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (bus.start) begin
                    state_d       = S_GEN;
                    score_d       = '0;
                    moves_d       = '0;
                    timeout_err_d = 1'b0;
                end
            end
            S_GEN: begin
                if (bus.gen_done) begin
                    board_we = 1'b1;
                    state_d  = S_PLAY;
                end else if (expired) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_PLAY: begin
                if (bus.confirm) begin
                    state_d = S_ELIM;
                    if (moves_q != 8'hFF) begin
                        moves_d = moves_q + 8'd1;
                    end
                end
            end
            S_ELIM: begin
                // done beats a same-cycle timeout
                if (bus.elim_done) begin
                    if (bus.elim_count != 7'd0) begin
                        score_d = SCORE_W'(score_sat_add(
                            32'(score_q), 32'(bus.elim_count),
                            SCORE_MAX));
                        state_d = S_REFILL;
                    end else begin
                        state_d = S_PLAY;
                    end
                end else if (expired) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_PLAY;
                end
            end
            S_REFILL: begin
                if (bus.refill_done) begin
                    board_we  = 1'b1;
                    board_sel = BOARD_SRC_REFRESH;
                    state_d   = win_reached ? S_OVER : S_PLAY;
                end else if (expired) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_PLAY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            score_q       <= '0;
            moves_q       <= '0;
            timeout_err_q <= 1'b0;
            gen_req_q     <= 1'b0;
            elim_req_q    <= 1'b0;
            refill_req_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_q       <= score_d;
            moves_q       <= moves_d;
            timeout_err_q <= timeout_err_d;
            gen_req_q     <= (state_d == S_GEN);
            elim_req_q    <= (state_d == S_ELIM);
            refill_req_q  <= (state_d == S_REFILL);
        end
    end

    assign bus.gen_req     = gen_req_q;
    assign bus.elim_req    = elim_req_q;
    assign bus.refill_req  = refill_req_q;
    assign bus.board_we    = board_we;
    assign bus.board_sel   = board_sel;
    assign bus.score       = score_q;
    assign bus.moves       = moves_q;
    assign bus.state       = state_q;
    assign bus.busy        = busy;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_board_sequencer.sv
// Self-checking bench for board_sequencer (TIMEOUT=16, WIN_SCORE=20).
// Build with SEQ_WIN_LIMIT_EN to exercise the win-limit behaviour.
module tb_board_sequencer;

    localparam int SW   = 10;
    localparam int SMAX = (1 << SW) - 1;
    localparam int WIN  = 20;
`ifdef SEQ_WIN_LIMIT_EN
    localparam int WIN_EN = 1;
`else
    localparam int WIN_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   we_cnt = 0;
    int   last_sel = 0;

    board_sequencer_if #(.SCORE_W(SW)) bus ();

    board_sequencer #(
        .TIMEOUT   (16),
        .SCORE_W   (SW),
        .WIN_SCORE (WIN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // board_we pulses counted mid-cycle, away from the rising edge
    always @(negedge clk) begin
        #2;
        if (bus.board_we) begin
            we_cnt++;
            last_sel = int'(bus.board_sel);
        end
    end

    typedef struct {
        int cnt;
        int dly;
        int exp_score;
        int exp_moves;
        int exp_we;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic new_game();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.gen_done = 1'b1;
        @(negedge clk);
        bus.gen_done = 1'b0;
    endtask

    task automatic move(input int cnt, input int dly);
        bus.confirm = 1'b1;
        @(negedge clk);
        bus.confirm = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (bus.elim_req) break;
            @(negedge clk);
        end
        repeat (dly) @(negedge clk);
        bus.elim_count = 7'(cnt);
        bus.elim_done  = 1'b1;
        @(negedge clk);
        bus.elim_done  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (bus.refill_req) begin
                repeat (dly) @(negedge clk);
                bus.refill_done = 1'b1;
                @(negedge clk);
                bus.refill_done = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    vec_t tbl[4];
    int   n, w0, es, em, c, d, win;

    initial begin
        tbl[0] = '{12, 2, 12, 1, 1};
        tbl[1] = '{0,  1, 12, 2, 0};
        tbl[2] = '{3,  0, 15, 3, 1};
        tbl[3] = '{0,  3, 15, 4, 0};

        bus.start = 0; bus.confirm = 0; bus.gen_done = 0;
        bus.elim_done = 0; bus.elim_count = 0; bus.refill_done = 0;

        // reset values
        #2 rst = 1'b1;
        #1;
        chk("rst_state", int'(bus.state), 0);
        chk("rst_reqs", int'({bus.gen_req, bus.elim_req,
                              bus.refill_req}), 0);
        chk("rst_we_sel", int'({bus.board_we, bus.board_sel}), 0);
        chk("rst_score", int'(bus.score), 0);
        chk("rst_moves", int'(bus.moves), 0);
        chk("rst_flags", int'({bus.busy, bus.game_over,
                               bus.timeout_err}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // generate with done after 5 cycles
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("gen_busy", int'(bus.busy), 1);
        n = 0;
        repeat (4) begin
            n += int'(bus.gen_req);
            @(negedge clk);
        end
        bus.gen_done = 1'b1;
        #1;
        n += int'(bus.gen_req);
        chk("gen_req_cycles", n, 5);
        chk("gen_we", int'(bus.board_we), 1);
        chk("gen_sel", int'(bus.board_sel), 0);
        @(negedge clk);
        bus.gen_done = 1'b0;
        chk("gen_state", int'(bus.state), 2);
        chk("gen_req_drop", int'(bus.gen_req), 0);
        chk("gen_we_drop", int'(bus.board_we), 0);

        // table of moves
        for (int i = 0; i < 4; i++) begin
            w0 = we_cnt;
            last_sel = 0;
            move(tbl[i].cnt, tbl[i].dly);
            chk("tbl_score", int'(bus.score), tbl[i].exp_score);
            chk("tbl_moves", int'(bus.moves), tbl[i].exp_moves);
            chk("tbl_state", int'(bus.state), 2);
            chk("tbl_we", we_cnt - w0, tbl[i].exp_we);
            chk("tbl_sel", last_sel, tbl[i].exp_we);
        end

        // ignored inputs
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_in_play_state", int'(bus.state), 2);
        chk("start_in_play_score", int'(bus.score), 15);
        w0 = we_cnt;
        bus.confirm = 1'b1;
        @(negedge clk);
        chk("elim_state", int'(bus.state), 3);
        @(negedge clk);
        bus.confirm = 1'b0;
        chk("confirm_in_elim", int'(bus.moves), 5);
        bus.elim_count = 7'd0;
        bus.elim_done = 1'b1;
        @(negedge clk);
        bus.elim_done = 1'b0;
        bus.gen_done = 1'b1;
        @(negedge clk);
        bus.gen_done = 1'b0;
        chk("zero_elim_state", int'(bus.state), 2);
        chk("zero_elim_score", int'(bus.score), 15);
        chk("zero_elim_we", we_cnt - w0, 0);

        // done on the last allowed cycle beats the timeout
        bus.confirm = 1'b1;
        @(negedge clk);
        bus.confirm = 1'b0;
        repeat (15) @(negedge clk);
        bus.elim_count = 7'd4;
        bus.elim_done = 1'b1;
        @(negedge clk);
        bus.elim_done = 1'b0;
        chk("late_done_state", int'(bus.state), 4);
        chk("late_done_terr", int'(bus.timeout_err), 0);
        bus.refill_done = 1'b1;
        @(negedge clk);
        bus.refill_done = 1'b0;
        chk("late_done_score", int'(bus.score), 19);

        // elim timeout
        bus.confirm = 1'b1;
        @(negedge clk);
        bus.confirm = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!bus.elim_req) break;
            n++;
            @(negedge clk);
        end
        chk("elim_to_cycles", n, 16);
        chk("elim_to_terr", int'(bus.timeout_err), 1);
        chk("elim_to_state", int'(bus.state), 2);
        chk("elim_to_moves", int'(bus.moves), 7);
        w0 = we_cnt;
        bus.elim_count = 7'd5;
        bus.elim_done = 1'b1;
        @(negedge clk);
        bus.elim_done = 1'b0;
        @(negedge clk);
        chk("stray_done_state", int'(bus.state), 2);
        chk("stray_done_score", int'(bus.score), 19);
        chk("stray_done_we", we_cnt - w0, 0);
        chk("terr_sticky", int'(bus.timeout_err), 1);

        // win limit
        new_game();
        w0 = we_cnt;
        move(15, 1);
        chk("win_pre_score", int'(bus.score), 15);
        move(8, 2);
        chk("win_score", int'(bus.score), 23);
        chk("win_state", int'(bus.state), WIN_EN ? 5 : 2);
        chk("win_game_over", int'(bus.game_over), WIN_EN);
        chk("win_we", we_cnt - w0, 2);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("restart_score", int'(bus.score), WIN_EN ? 0 : 23);
        chk("restart_state", int'(bus.state), WIN_EN ? 1 : 2);

        // generator timeout
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!bus.gen_req) break;
            n++;
            @(negedge clk);
        end
        chk("gen_to_cycles", n, 16);
        chk("gen_to_state", int'(bus.state), 0);
        chk("gen_to_terr", int'(bus.timeout_err), 1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("gen_to_restart", int'(bus.state), 1);
        chk("gen_to_clear", int'(bus.timeout_err), 0);

        // reset in the middle of a refill
        new_game();
        bus.confirm = 1'b1;
        @(negedge clk);
        bus.confirm = 1'b0;
        bus.elim_count = 7'd5;
        bus.elim_done = 1'b1;
        @(negedge clk);
        bus.elim_done = 1'b0;
        chk("pre_rst_state", int'(bus.state), 4);
        #3 rst = 1'b1;
        #1;
        chk("async_state", int'(bus.state), 0);
        chk("async_reqs", int'({bus.gen_req, bus.elim_req,
                                bus.refill_req}), 0);
        chk("async_score", int'(bus.score), 0);
        chk("async_moves", int'(bus.moves), 0);
        chk("async_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.refill_done = 1'b1;
        #1;
        chk("post_rst_we", int'(bus.board_we), 0);
        @(negedge clk);
        bus.refill_done = 1'b0;
        chk("post_rst_state", int'(bus.state), 0);

        // randomized moves against a transaction-level model
        new_game();
        es = 0;
        em = 0;
        for (int i = 0; i < 300; i++) begin
            c = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(64, 1));
            d = int'($urandom_range(5));
            w0 = we_cnt;
            last_sel = 0;
            move(c, d);
            em = (em < 255) ? em + 1 : 255;
            if (c > 0) es = (es + c > SMAX) ? SMAX : es + c;
            win = (WIN_EN != 0 && c > 0 && es >= WIN) ? 1 : 0;
            chk("rnd_score", int'(bus.score), es);
            chk("rnd_moves", int'(bus.moves), em);
            chk("rnd_state", int'(bus.state), win ? 5 : 2);
            chk("rnd_we", we_cnt - w0, (c > 0) ? 1 : 0);
            chk("rnd_sel", last_sel, (c > 0) ? 1 : 0);
            if (win != 0) begin
                new_game();
                es = 0;
                em = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/board_sequencer.md
BOARD_SEQUENCER -- requirements
Module: board_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, the cycle limit per GEN/ELIM/REFILL phase before abort.
REQ-002 SHALL have parameter SCORE_W, default 10, the score register width.
REQ-003 SHALL have parameter WIN_SCORE, default 500, the score threshold used only under SEQ_WIN_LIMIT_EN.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse; begins a game from IDLE or OVER.
REQ-007 confirm  input  1  one-cycle pulse; player elimination request from the cursor logic.
REQ-008 gen_done  input  1  generator finished; new board valid.
REQ-009 elim_done  input  1  eliminator finished; elim_count valid in the same cycle.
REQ-010 elim_count  input  7  cells removed, range 0..64.
REQ-011 refill_done  input  1  refresh unit finished; refilled board valid.
REQ-012 gen_req, elim_req, refill_req  output  1 each  level requests, high throughout GEN, ELIM and REFILL respectively.
REQ-013 board_we  output  1  one-cycle strobe telling the top level to latch the board source.
REQ-014 board_sel  output  1  board source: 0 = generator, 1 = refresh; valid whenever board_we is high.
REQ-015 score  output  SCORE_W  accumulated score.
REQ-016 moves  output  8  count of confirms accepted.
REQ-017 state  output  3  encoded FSM state, for seven-segment debug.
REQ-018 busy, game_over, timeout_err  output  1 each  status flags.

Function
REQ-019 FSM states and encodings SHALL be IDLE=0, GEN=1, PLAY=2, ELIM=3, REFILL=4, OVER=5; state SHALL equal the current encoding.
REQ-020 IDLE/OVER + start SHALL go to GEN, clear score and moves, and clear timeout_err.
REQ-021 GEN + gen_done SHALL pulse board_we with board_sel=0 in the same cycle and go to PLAY next cycle.
REQ-022 PLAY + confirm SHALL go to ELIM and increment moves, saturating at 255.
REQ-023 ELIM + elim_done with elim_count=0 SHALL return to PLAY with no board_we and no score change.
REQ-024 ELIM + elim_done with elim_count>0 SHALL add elim_count to score, saturating at 2^SCORE_W-1, and go to REFILL.
REQ-025 REFILL + refill_done SHALL pulse board_we with board_sel=1 and go to PLAY.
REQ-026 Request outputs SHALL be registered and decoded from state: asserted the cycle after entry, deasserted the cycle after the matching done is sampled.
REQ-027 confirm outside PLAY, start outside IDLE/OVER, and any done pulse outside its matching state SHALL be ignored.
REQ-028 start and confirm high in the same cycle SHALL be resolved by the current state only; at most one is meaningful in any state.
REQ-029 A phase counter SHALL clear on entry to each of GEN, ELIM and REFILL and increment each cycle in that phase.
REQ-030 When the phase counter reaches TIMEOUT-1 without the matching done, the block SHALL set timeout_err (sticky), drop the request, go to IDLE from GEN, and go to PLAY from ELIM/REFILL, with no board_we and no score change.
REQ-031 A done arriving in the same cycle as timeout SHALL win; the timeout is not taken.
REQ-032 busy SHALL be high in GEN, ELIM and REFILL; game_over SHALL be high only in OVER.

Reset
REQ-033 rst SHALL asynchronously force IDLE, all requests 0, board_we 0, board_sel 0, score 0, moves 0, timeout_err 0, and the phase counter 0.
REQ-034 rst mid-phase SHALL abandon the phase; done pulses arriving after release SHALL be ignored per REQ-027.

Configuration
REQ-035 With SEQ_WIN_LIMIT_EN defined, the REFILL to PLAY transition SHALL instead go to OVER when the updated score >= WIN_SCORE; board_we still pulses.
REQ-036 Without SEQ_WIN_LIMIT_EN, OVER SHALL be unreachable, game_over SHALL be constant 0, and WIN_SCORE SHALL be unused.

Structure
REQ-037 Package seq_pkg SHALL hold the state encodings, the BOARD_SRC_GEN=0 / BOARD_SRC_REFRESH=1 constants, and the score saturating-add function.
REQ-038 One sub-module, seq_phase_timer, SHALL hold the phase counter and timeout compare: inputs clear and enable; output expired.

Verification
REQ-039 Reset, then start; gen_done after 5 cycles -> gen_req high for 5 cycles; board_we=1 and board_sel=0 for one cycle; state=2.
REQ-040 In PLAY: confirm, elim_done with elim_count=12, refill_done -> score=12, moves=1, board_we with board_sel=1, state=2.
REQ-041 confirm then elim_done with elim_count=0 -> state returns to 2, no board_we, score unchanged; confirm in ELIM is ignored and moves is not incremented.
REQ-042 TIMEOUT=16; confirm with no elim_done -> after 16 cycles in ELIM, timeout_err=1, elim_req=0, state=2; a late elim_done is ignored.
REQ-043 SEQ_WIN_LIMIT_EN defined, WIN_SCORE=20, score=15; eliminate 8 then refill -> score=23, state=5, game_over=1; start -> score=0, state=1.
REQ-044 Assert rst during REFILL -> all outputs at reset values immediately, before the next clk edge; a subsequent refill_done causes no board_we.
